// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Round-robin arbiter that shares one 2:1 mux datapath between two
// requesters. Requester 0 drives `a` and requester 1 drives `b`. The
// arbiter owns the mux select, issues one-hot registered grants, and
// limits how long one side can hold the mux while the other side waits.
//
// Parameters:
//   W        - data width of a, b and y
//   MAX_HOLD - maximum consecutive grant cycles for one requester while
//              the other requests (legal range 1..255)
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous, active-high reset
//   req0     - requester 0 wants the mux (data on a)
//   req1     - requester 1 wants the mux (data on b)
//   a, b     - requester data
//   gnt0     - registered grant to requester 0
//   gnt1     - registered grant to requester 1
//   sel      - registered mux select (0 = a, 1 = b)
//   y        - selected data while a grant is active, otherwise zero
//   y_valid  - gnt0 | gnt1
//   cnt0/1   - (MUX2_ARBITER_STATS_EN only) saturating counts of the
//              cycles in which gnt0/gnt1 is high
//
// Optional feature macro: MUX2_ARBITER_STATS_EN
module mux2_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [W-1:0] y,
    output logic         y_valid
`ifdef MUX2_ARBITER_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("mux2_arbiter: MAX_HOLD must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    // Owner of the most recent grant; the other side wins an IDLE tie.
    logic       last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    state_nxt = req1 ? G1 : IDLE;
                end else if (req1 && hold_cnt == HOLD_LAST) begin
                    state_nxt = G1;
                end
            end
            G1: begin
                if (!req1) begin
                    state_nxt = req0 ? G0 : IDLE;
                end else if (req0 && hold_cnt == HOLD_LAST) begin
                    state_nxt = G0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            hold_cnt <= 8'd0;
            last     <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt0  <= (state_nxt == G0);
            gnt1  <= (state_nxt == G1);
            if (state_nxt == G0 && state != G0) begin
                sel      <= 1'b0;
                last     <= 1'b0;
                hold_cnt <= 8'd0;
            end else if (state_nxt == G1 && state != G1) begin
                sel      <= 1'b1;
                last     <= 1'b1;
                hold_cnt <= 8'd0;
            end else if (state_nxt != IDLE && hold_cnt != HOLD_LAST) begin
                // Staying in a grant: count up, saturating so a lone
                // requester keeps the mux for as long as it likes.
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign y_valid = gnt0 | gnt1;
    assign y       = y_valid ? (sel ? b : a) : '0;

`ifdef MUX2_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (gnt0 && cnt0 != 16'hFFFF) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (gnt1 && cnt1 != 16'hFFFF) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a, b;
    logic       gnt0, gnt1, sel, y_valid;
    logic [3:0] y;

    logic       h_req0, h_req1;
    logic [3:0] h_a, h_b;
    logic       h_gnt0, h_gnt1, h_sel, h_y_valid;
    logic [3:0] h_y;

`ifdef MUX2_ARBITER_STATS_EN
    logic [15:0] cnt0, cnt1, h_cnt0, h_cnt1;
`endif

    int errors;
    int checks;

    mux2_arbiter #(.W(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a(a), .b(b),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
`ifdef MUX2_ARBITER_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    mux2_arbiter #(.W(4), .MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst(rst), .req0(h_req0), .req1(h_req1), .a(h_a), .b(h_b),
        .gnt0(h_gnt0), .gnt1(h_gnt1), .sel(h_sel), .y(h_y), .y_valid(h_y_valid)
`ifdef MUX2_ARBITER_STATS_EN
        , .cnt0(h_cnt0), .cnt1(h_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; a = 4'h0; b = 4'h1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({gnt0, gnt1, sel, y_valid, y} !== 8'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got gnt0=%b gnt1=%b sel=%b vld=%b y=%h want all 0",
                         i, gnt0, gnt1, sel, y_valid, y);
            end
        end
`ifdef MUX2_ARBITER_STATS_EN
        checks++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tie got gnt0=%b gnt1=%b sel=%b want 1 0 0", gnt0, gnt1, sel);
        end
    endtask

    task automatic test_single();
        do_reset();
        a = 4'h5; b = 4'hA; req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || y !== 4'h5 || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_hold cyc=%0d got gnt0=%b gnt1=%b y=%h vld=%b want 1 0 5 1",
                         i, gnt0, gnt1, y, y_valid);
            end
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || y_valid !== 1'b0 || y !== 4'h0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL single_drop got gnt0=%b vld=%b y=%h sel=%b want 0 0 0 0", gnt0, y_valid, y, sel);
        end
    endtask

    task automatic test_contention();
        logic exp_g1;
        do_reset();
        a = 4'h3; b = 4'hC; req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_g1 = (((k - 1) / 4) % 2) == 1;
            checks++;
            if (gnt0 !== !exp_g1 || gnt1 !== exp_g1 || sel !== exp_g1 ||
                y !== (exp_g1 ? 4'hC : 4'h3) || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL contention cyc=%0d got gnt0=%b gnt1=%b sel=%b y=%h want gnt1=%b y=%h",
                         k, gnt0, gnt1, sel, y, exp_g1, exp_g1 ? 4'hC : 4'h3);
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        a = 4'h6; b = 4'h9; req1 = 1'b1;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || y !== 4'h9 || sel !== 1'b1) begin
            errors++;
            $display("FAIL handoff_g1 got gnt0=%b gnt1=%b y=%h sel=%b want 0 1 9 1", gnt0, gnt1, y, sel);
        end
        req1 = 1'b0; req0 = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || y_valid !== 1'b1 || y !== 4'h6 || sel !== 1'b0) begin
            errors++;
            $display("FAIL handoff_g0 got gnt0=%b gnt1=%b vld=%b y=%h sel=%b want 1 0 1 6 0",
                     gnt0, gnt1, y_valid, y, sel);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (y_valid !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL handoff_idle got vld=%b sel=%b want 0 0", y_valid, sel);
        end
        // Requester 0 was served last, so requester 1 wins this tie.
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL handoff_tie got gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a = 4'h2; b = 4'h7; req1 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got gnt1=%b want 1", gnt1);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, sel, y_valid, y} !== 8'b0) begin
            errors++;
            $display("FAIL midrst_outputs got gnt0=%b gnt1=%b sel=%b vld=%b y=%h want all 0",
                     gnt0, gnt1, sel, y_valid, y);
        end
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || y !== 4'h2) begin
            errors++;
            $display("FAIL midrst_after got gnt0=%b gnt1=%b y=%h want 1 0 2", gnt0, gnt1, y);
        end
    endtask

    task automatic test_max_hold1();
        logic exp_g1;
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1; h_req0 = 1'b0; h_req1 = 1'b0;
        tick();
        rst = 1'b0;
        h_a = 4'h1; h_b = 4'hE; h_req0 = 1'b1; h_req1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_g1 = ((k - 1) % 2) == 1;
            checks++;
            if (h_gnt0 !== !exp_g1 || h_gnt1 !== exp_g1 || h_y !== (exp_g1 ? 4'hE : 4'h1)) begin
                errors++;
                $display("FAIL hold1_alt cyc=%0d got gnt0=%b gnt1=%b y=%h want gnt1=%b",
                         k, h_gnt0, h_gnt1, h_y, exp_g1);
            end
        end
        h_req0 = 1'b0; h_req1 = 1'b0;
        tick();
        checks++;
        if (h_y_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold1_idle got vld=%b want 0", h_y_valid);
        end
`ifdef MUX2_ARBITER_STATS_EN
        checks++;
        if (h_cnt0 !== 16'd10 || h_cnt1 !== 16'd10) begin
            errors++;
            $display("FAIL stats_cnt got cnt0=%0d cnt1=%0d want 10 10", h_cnt0, h_cnt1);
        end
`endif
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; a = 4'h0; b = 4'h0;
        h_req0 = 1'b0; h_req1 = 1'b0; h_a = 4'h0; h_b = 4'h0;
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_reset_mid();
        test_max_hold1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
